// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the LED mode controller.
//   mode_t     - display mode encoding, in button-advance order
//   LED_W      - width of the LED bank and switch bank
//   SHIFT_SEED - pattern loaded on entry to the rotating-LED mode
//   next_mode  - successor mode on a button press (wraps BLINK -> MIRROR)
package led_ctrl_pkg;

  localparam int unsigned LED_W = 16;
  localparam logic [LED_W-1:0] SHIFT_SEED = 16'h0001;

  typedef enum logic [1:0] {
    MODE_MIRROR,
    MODE_SHIFT,
    MODE_COUNT,
    MODE_BLINK
  } mode_t;

  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    unique case (cur)
      MODE_MIRROR: nxt = MODE_SHIFT;
      MODE_SHIFT:  nxt = MODE_COUNT;
      MODE_COUNT:  nxt = MODE_BLINK;
      MODE_BLINK:  nxt = MODE_MIRROR;
      default:     nxt = MODE_MIRROR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw bouncing button, qualifies level changes that stay
// stable for DEBOUNCE_CYCLES cycles, and emits a one-cycle pulse on the debounced rising edge.
//   clk     - system clock (rising edge)
//   reset   - asynchronous active-high reset
//   btn_raw - raw asynchronous button input
//   level   - debounced button level
//   press   - one-cycle pulse when the debounced level rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            db_q, db_d;
  logic            db_prev_q, db_prev_d;
  logic [CntW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    dcnt_d    = dcnt_q;
    // Any return to the accepted level restarts qualification from zero.
    if (s2_q == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == CntMax) begin
      db_d   = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign level = db_q;
  assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: owner of the 16 user LEDs. A debounced push-button steps through four display
// modes (switch mirror, rotating single LED, binary tick counter, blinking switch mirror); an
// animation tick advances the per-mode state.
//   clk      - system clock (rising edge)
//   reset    - asynchronous active-high reset
//   sw       - switch levels, quasi-static, used unsynchronised
//   btn_next - raw bouncing mode-advance button, active-high
//   led      - registered LED drive
//   mode     - registered current mode (mode_t encoding)
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] sw,
  input  logic             btn_next,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int unsigned TickW = $clog2(TICK_CYCLES);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CYCLES - 1);

  logic press;
  logic unused_btn_level;
  logic tick;

  mode_t            mode_q, mode_d;
  logic [TickW-1:0] tcnt_q, tcnt_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [LED_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [LED_W-1:0] led_q, led_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_next),
    .level  (unused_btn_level),
    .press  (press)
  );

  assign tick = (tcnt_q == TickMax);

  always_comb begin
    mode_d  = mode_q;
    tcnt_d  = tcnt_q + TickW'(1);
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    // A press restarts the tick period so the first tick in a new mode is a full period away.
    if (press || tick) begin
      tcnt_d = '0;
    end

    if (press) begin
      // Entry values are loaded for the mode being entered; a coincident tick is dropped.
      mode_d = next_mode(mode_q);
      unique case (mode_d)
        MODE_SHIFT:  pat_d   = SHIFT_SEED;
        MODE_COUNT:  cnt_d   = '0;
        MODE_BLINK:  phase_d = 1'b1;
        MODE_MIRROR: ;
        default:     ;
      endcase
    end else if (tick) begin
      unique case (mode_q)
        MODE_SHIFT:  pat_d   = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        MODE_COUNT:  cnt_d   = cnt_q + LED_W'(1);
        MODE_BLINK:  phase_d = ~phase_q;
        MODE_MIRROR: ;
        default:     ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    unique case (mode_q)
      MODE_MIRROR: led_d = sw;
      MODE_SHIFT:  led_d = pat_q;
      MODE_COUNT:  led_d = cnt_q;
      MODE_BLINK:  led_d = phase_q ? sw : '0;
      default:     led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_MIRROR;
      tcnt_q  <= '0;
      pat_q   <= SHIFT_SEED;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      tcnt_q  <= tcnt_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
